// File: rtl/stopwatch_lap_core.sv
// MM:SS stopwatch datapath with lap capture/recall, sticky overflow,
// idle display blanking and a multiplexed seven-segment driver.
module stopwatch_lap_core #(
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned SCAN_DIV  = 50_000,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned IDLE_CYC  = 1_500_000_000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_stop,
    input  logic                             lap,
    input  logic                             recall,
    input  logic                             clear_laps,
    output logic                             running,
    output logic                             overflow,
    output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_count,
    output logic                             viewing,
    output logic [3:0]                       anode,
    output logic [7:0]                       seg
);

    localparam int unsigned TW   = $clog2(TICK_DIV);
    localparam int unsigned SW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW   = $clog2(LAP_DEPTH + 1);
    localparam int unsigned PTRW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int unsigned IW   = $clog2(IDLE_CYC + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(LAP_DEPTH);
    localparam logic [IW-1:0] IDLE_C    = IW'(IDLE_CYC);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

    typedef enum logic {
        MODE_LIVE = 1'b0,
        MODE_VIEW = 1'b1
    } mode_t;

    mode_t           mode_q, mode_d;
    logic [TW-1:0]   presc_q, presc_d;
    logic [3:0]      s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic            running_q, running_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   lap_cnt_q, lap_cnt_d;
    logic [PTRW-1:0] ptr_q, ptr_d;
    logic [SW-1:0]   scan_q, scan_d;
    logic [1:0]      idx_q, idx_d;
    logic [IW-1:0]   idle_q, idle_d;
    logic            blanked_q, blanked_d;
    logic [15:0]     laps_q [LAP_DEPTH];

    logic            pulse_any, wake;
    logic            do_clear, do_ss, do_lap, do_rec;
    logic            tick, wrap, lap_we;
    logic [15:0]     live_time, view_time, disp_time;
    logic [3:0]      digit;
    logic            dp_on;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign live_time = {m10_q, m1_q, s10_q, s1_q};

    // Next-state: command decode, prescaler, BCD time, laps, view mode, idle, scan
    always_comb begin
        mode_d     = mode_q;
        presc_d    = presc_q;
        s1_d       = s1_q;
        s10_d      = s10_q;
        m1_d       = m1_q;
        m10_d      = m10_q;
        running_d  = running_q;
        lap_cnt_d  = lap_cnt_q;
        ptr_d      = ptr_q;
        wrap       = 1'b0;
        lap_we     = 1'b0;

        // A pulse that wakes the display is swallowed; otherwise the highest
        // priority pulse wins: clear_laps > start_stop > lap > recall.
        pulse_any = start_stop | lap | recall | clear_laps;
        wake      = blanked_q & pulse_any;
        do_clear  = ~wake & clear_laps;
        do_ss     = ~wake & ~clear_laps & start_stop;
        do_lap    = ~wake & ~clear_laps & ~start_stop & lap;
        do_rec    = ~wake & ~clear_laps & ~start_stop & ~lap & recall;

        tick = running_q && (presc_q == TICK_LAST);

        if (running_q) begin
            presc_d = tick ? '0 : presc_q + TW'(1);
        end

        if (tick) begin
            if (s1_q != 4'd9) begin
                s1_d = s1_q + 4'd1;
            end else begin
                s1_d = '0;
                if (s10_q != 4'd5) begin
                    s10_d = s10_q + 4'd1;
                end else begin
                    s10_d = '0;
                    if (m1_q != 4'd9) begin
                        m1_d = m1_q + 4'd1;
                    end else begin
                        m1_d = '0;
                        if (m10_q != 4'd5) begin
                            m10_d = m10_q + 4'd1;
                        end else begin
                            m10_d = '0;
                            wrap  = 1'b1;
                        end
                    end
                end
            end
        end

        overflow_d = overflow_q | wrap;

        if (do_ss) begin
            running_d = ~running_q;
        end

        if (do_lap) begin
            if (running_q) begin
                if (lap_cnt_q != DEPTH_C) begin
                    lap_we    = 1'b1;
                    lap_cnt_d = lap_cnt_q + CW'(1);
                end
            end else begin
                // Stopped: lap zeroes the time (never coincides with a tick).
                s1_d    = '0;
                s10_d   = '0;
                m1_d    = '0;
                m10_d   = '0;
                presc_d = '0;
            end
        end

        if (do_rec && (lap_cnt_q != '0)) begin
            case (mode_q)
                MODE_LIVE: begin
                    mode_d = MODE_VIEW;
                    ptr_d  = '0;
                end
                MODE_VIEW: begin
                    if ((CW'(ptr_q) + CW'(1)) < lap_cnt_q) begin
                        ptr_d = ptr_q + PTRW'(1);
                    end else begin
                        mode_d = MODE_LIVE;
                    end
                end
                default: mode_d = MODE_LIVE;
            endcase
        end

        if (do_clear) begin
            lap_cnt_d  = '0;
            mode_d     = MODE_LIVE;
            ptr_d      = '0;
            overflow_d = 1'b0;
        end

        blanked_d = blanked_q & ~pulse_any;
        if (pulse_any || running_q) begin
            idle_d = '0;
        end else if (idle_q != IDLE_C) begin
            idle_d = idle_q + IW'(1);
            if (idle_q == IDLE_LAST) begin
                blanked_d = 1'b1;
            end
        end else begin
            idle_d = idle_q;
        end

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end else begin
            scan_d = scan_q + SW'(1);
            idx_d  = idx_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_LIVE;
            presc_q    <= '0;
            s1_q       <= '0;
            s10_q      <= '0;
            m1_q       <= '0;
            m10_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
            lap_cnt_q  <= '0;
            ptr_q      <= '0;
            scan_q     <= '0;
            idx_q      <= '0;
            idle_q     <= '0;
            blanked_q  <= 1'b0;
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                laps_q[i] <= '0;
            end
        end else begin
            mode_q     <= mode_d;
            presc_q    <= presc_d;
            s1_q       <= s1_d;
            s10_q      <= s10_d;
            m1_q       <= m1_d;
            m10_q      <= m10_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
            lap_cnt_q  <= lap_cnt_d;
            ptr_q      <= ptr_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            idle_q     <= idle_d;
            blanked_q  <= blanked_d;
            for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
                if (lap_we && (lap_cnt_q == CW'(i))) begin
                    laps_q[i] <= live_time;
                end
            end
        end
    end

    // Display: pick source, select digit, encode segments and anode
    always_comb begin
        view_time = '0;
        for (int unsigned i = 0; i < LAP_DEPTH; i++) begin
            if (ptr_q == PTRW'(i)) begin
                view_time = laps_q[i];
            end
        end

        disp_time = (mode_q == MODE_VIEW) ? view_time : live_time;

        case (idx_q)
            2'd0:    digit = disp_time[3:0];
            2'd1:    digit = disp_time[7:4];
            2'd2:    digit = disp_time[11:8];
            default: digit = disp_time[15:12];
        endcase

        dp_on = (idx_q == 2'd2) &&
                ((mode_q == MODE_VIEW) || running_q || (live_time != '0));

        if (blanked_q) begin
            anode = 4'b0000;
            seg   = 8'hFF;
        end else begin
            anode = 4'b0001 << idx_q;
            seg   = {~dp_on, seg7(digit)};
        end
    end

    assign running   = running_q;
    assign overflow  = overflow_q;
    assign lap_count = lap_cnt_q;
    assign viewing   = (mode_q == MODE_VIEW);

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core with small timing parameters.
module tb_stopwatch_lap_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop, lap, recall, clear_laps;
    logic       running, overflow, viewing;
    logic [1:0] lap_count;
    logic [3:0] anode;
    logic [7:0] seg;

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0] bcd;
    logic        dp2;

    stopwatch_lap_core #(
        .TICK_DIV (4),
        .SCAN_DIV (2),
        .LAP_DEPTH(2),
        .IDLE_CYC (40)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_stop(start_stop),
        .lap       (lap),
        .recall    (recall),
        .clear_laps(clear_laps),
        .running   (running),
        .overflow  (overflow),
        .lap_count (lap_count),
        .viewing   (viewing),
        .anode     (anode),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        case (s)
            7'h40:   seg2dig = 4'd0;
            7'h79:   seg2dig = 4'd1;
            7'h24:   seg2dig = 4'd2;
            7'h30:   seg2dig = 4'd3;
            7'h19:   seg2dig = 4'd4;
            7'h12:   seg2dig = 4'd5;
            7'h02:   seg2dig = 4'd6;
            7'h78:   seg2dig = 4'd7;
            7'h00:   seg2dig = 4'd8;
            7'h10:   seg2dig = 4'd9;
            default: seg2dig = 4'hF;
        endcase
    endfunction

    // Called at a negedge; single-cycle pulse on the selected inputs.
    task automatic pulse(input logic ss, input logic lp, input logic rc, input logic cl);
        start_stop = ss; lap = lp; recall = rc; clear_laps = cl;
        @(negedge clk);
        start_stop = 1'b0; lap = 1'b0; recall = 1'b0; clear_laps = 1'b0;
    endtask

    // Collects one full scan (8 cycles) of the display into BCD digits.
    task automatic read_display(output logic [15:0] v, output logic dp);
        v  = 16'hFFFF;
        dp = 1'b0;
        for (int k = 0; k < 8; k++) begin
            case (anode)
                4'b0001: v[3:0]   = seg2dig(seg[6:0]);
                4'b0010: v[7:4]   = seg2dig(seg[6:0]);
                4'b0100: begin
                    v[11:8] = seg2dig(seg[6:0]);
                    dp      = ~seg[7];
                end
                4'b1000: v[15:12] = seg2dig(seg[6:0]);
                default: ;
            endcase
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_stop = 1'b0; lap = 1'b0; recall = 1'b0; clear_laps = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state, scan sequence, basic counting
        do_reset();
        check("rst_anode", anode, 4'b0001);
        check("rst_seg", seg, 8'hC0);
        check("rst_running", running, 0);
        check("rst_overflow", overflow, 0);
        check("rst_lap_count", lap_count, 0);
        check("rst_viewing", viewing, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("scan_%0d", i), anode, 4'b0001 << ((i / 2) % 4));
            @(negedge clk);
        end
        pulse(1, 0, 0, 0);
        repeat (40) @(negedge clk);
        check("t1_running", running, 1);
        pulse(1, 0, 0, 0);
        check("t1_stopped", running, 0);
        read_display(bcd, dp2);
        check("t1_time", bcd, 16'h0010);
        check("t1_dp", dp2, 1);

        // 2: 59:59 -> 00:00 wrap with sticky overflow
        do_reset();
        pulse(1, 0, 0, 0);
        repeat (14396) @(negedge clk);
        check("t2_ovf_before", overflow, 0);
        repeat (4) @(negedge clk);
        check("t2_ovf_set", overflow, 1);
        pulse(1, 0, 0, 0);
        read_display(bcd, dp2);
        check("t2_time_wrap", bcd, 16'h0000);
        check("t2_dp_zero_stopped", dp2, 0);
        check("t2_ovf_sticky", overflow, 1);
        pulse(0, 0, 0, 1);
        check("t2_ovf_cleared", overflow, 0);

        // 3: lap capture (incl. on a tick cycle), full buffer, recall
        pulse(0, 0, 1, 0);
        check("t3_recall_empty", viewing, 0);
        pulse(0, 1, 0, 0);
        pulse(1, 0, 0, 0);
        repeat (15) @(negedge clk);
        pulse(0, 1, 0, 0);
        repeat (13) @(negedge clk);
        pulse(0, 1, 0, 0);
        repeat (6) @(negedge clk);
        pulse(0, 1, 0, 0);
        check("t3_lap_count", lap_count, 2);
        pulse(0, 0, 1, 0);
        check("t3_view1", viewing, 1);
        read_display(bcd, dp2);
        check("t3_lap0", bcd, 16'h0003);
        check("t3_view_dp", dp2, 1);
        pulse(0, 0, 1, 0);
        check("t3_view2", viewing, 1);
        read_display(bcd, dp2);
        check("t3_lap1", bcd, 16'h0007);
        pulse(0, 0, 1, 0);
        check("t3_live", viewing, 0);

        // 4: start_stop beats lap; stopped lap zeroes time only
        pulse(0, 0, 0, 1);
        check("t4_cleared", lap_count, 0);
        pulse(0, 1, 0, 0);
        check("t4_one_lap", lap_count, 1);
        pulse(1, 1, 0, 0);
        check("t4_stopped", running, 0);
        check("t4_no_lap", lap_count, 1);
        read_display(bcd, dp2);
        check("t4_time_kept", bcd != 16'h0000, 1);
        check("t4_dp_nonzero", dp2, 1);
        pulse(0, 1, 0, 0);
        check("t4_lap_kept", lap_count, 1);
        read_display(bcd, dp2);
        check("t4_zeroed", bcd, 16'h0000);
        check("t4_dp_off", dp2, 0);

        // 5: idle blanking and wake
        repeat (31) @(negedge clk);
        check("t5_not_blank", anode != 4'b0000, 1);
        @(negedge clk);
        check("t5_blank_anode", anode, 4'b0000);
        check("t5_blank_seg", seg, 8'hFF);
        pulse(1, 0, 0, 0);
        check("t5_wake_running", running, 0);
        check("t5_wake_anode", anode != 4'b0000, 1);
        pulse(1, 0, 0, 0);
        check("t5_run", running, 1);

        // 6: reset on a tick cycle with lap pending
        repeat (3) @(negedge clk);
        reset = 1'b1;
        lap   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        lap   = 1'b0;
        check("t6_running", running, 0);
        check("t6_lap_count", lap_count, 0);
        check("t6_overflow", overflow, 0);
        check("t6_viewing", viewing, 0);
        check("t6_anode", anode, 4'b0001);
        check("t6_seg", seg, 8'hC0);
        read_display(bcd, dp2);
        check("t6_time", bcd, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
